mbr_store_buffer: RTL and testbench
===================================

// Module: mbr_store_buffer
// PURPOSE
//   Parametrised memory buffer register for the CPU datapath.
//   - Loads use a req/ack handshake with memory.
//   - ACC stores are posted into a DEPTH-entry FIFO that drains to memory via valid/ready.
//   - The load FSM enforces load-after-store ordering, so the control unit can continue past a store.
// PARAMETERS
//   DW     16  data width (ACC, memory and MBR data)
//   AW     8   address width
//   DEPTH  4   store FIFO entries; power of two, >=2
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   ld_req        in   1      start load of addr_in; sampled only when busy=0
//   st_req        in   1      post store of {addr_in, acc_in}
//   addr_in       in   AW     load/store address
//   acc_in        in   DW     store data from ACC
//   mbr_out       out  DW     last loaded word, held until next load completes
//   mbr_valid     out  1      one-cycle pulse: mbr_out updated this cycle
//   busy          out  1      load FSM not IDLE
//   st_full       out  1      FIFO count == DEPTH
//   st_overflow   out  1      sticky: st_req seen while full; cleared by reset only
//   mem_rd_req    out  1      read request, held until mem_rd_ack
//   mem_rd_addr   out  AW     read address, stable while mem_rd_req=1
//   mem_rd_ack    in   1      read data valid this cycle
//   mem_rd_data   in   DW     read data
//   mem_wr_valid  out  1      FIFO head valid (FIFO non-empty)
//   mem_wr_addr   out  AW     FIFO head address
//   mem_wr_data   out  DW     FIFO head data
//   mem_wr_ready  in   1      memory accepts head this cycle
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - All outputs 0; FIFO emptied; st_overflow=0; FSM=IDLE.
//   - A mem_rd_ack arriving after reset is ignored.
//   Store FIFO:
//   - Push on st_req && !st_full.
//   - Pop on mem_wr_valid && mem_wr_ready.
//   - Push and pop in the same cycle both occur; count unchanged.
//   - st_req while full: store dropped; st_overflow set next edge.
//   - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//   - mem_wr_* is driven from registered FIFO head: 0-cycle handshake, no bubble.
//   Load FSM:
//   - IDLE: ld_req latches addr_in. If FIFO empty after this cycle's push/pop, go to RD; else go to DRAIN.
//   - DRAIN: wait until FIFO empty, then go to RD.
//   - RD: mem_rd_req=1 with latched address. On mem_rd_ack: mbr_out<=mem_rd_data, mbr_valid=1 next cycle, go to IDLE.
//   - Minimum load latency, empty FIFO, ack in first RD cycle: ld_req at edge T, mem_rd_req high T+1, mbr_valid at T+2.
//   - ld_req while busy=1 is ignored.
//   - st_req and ld_req in the same cycle: the store is older and is enqueued first; the load must observe it.
//   - Stores accepted while busy are still posted normally.
// CONFIGURATION
//   MBR_FWD_EN defined:
//   - In IDLE, if ld_req address matches any valid FIFO entry, including the same-cycle st_req, return the youngest match.
//   - Result: mbr_out updated, mbr_valid pulses next cycle, FSM stays IDLE, no memory read.
//   - A miss follows the normal path.
//   MBR_FWD_EN undefined:
//   - No compare logic; every load with a non-empty FIFO goes through DRAIN.
// TESTING
//   1. Reset, ld_req addr=0x10, memory acks 0xBEEF after 3 cycles
//      -> mem_rd_req high 3 cycles, mbr_out=0xBEEF, 1-cycle mbr_valid.
//   2. 4 st_req (0x01..0x04 -> 0xA001..A004) with mem_wr_ready=0
//      -> st_full=1; 5th st_req sets st_overflow; ready=1 drains in order.
//   3. st_req 0x20=0x1234 then ld_req 0x20, ready held 0 for 5 cycles
//      -> fwd off: DRAIN until write pops, then read;
//      -> MBR_FWD_EN: mbr_out=0x1234 with no mem_rd_req.
//   4. Push and pop in the same cycle at count=2
//      -> count stays 2; wrap past DEPTH x3 keeps data order.
//   5. rst_n low while in RD with a pending ack
//      -> all outputs 0 immediately, FIFO empty, later ack ignored.

Source files
------------

// File: rtl/mbr_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mbr_store_buffer
// Purpose  : Memory buffer register for the CPU datapath. Loads use a req/ack
//            handshake with memory. ACC stores are posted into a DEPTH-entry
//            FIFO that drains to memory over valid/ready. The load FSM holds a
//            load back until older stores have left the FIFO.
// Options  : MBR_FWD_EN - when defined, a load whose address matches a queued
//            store (or a store in the same cycle) is answered from the FIFO
//            without a memory read.
// Ports    : clk, rst_n (async, active low)
//            ld_req/st_req/addr_in/acc_in    - control unit requests
//            mbr_out/mbr_valid               - load result and update pulse
//            busy/st_full/st_overflow        - status
//            mem_rd_req/addr, mem_rd_ack/data - memory read handshake
//            mem_wr_valid/addr/data, mem_wr_ready - memory write handshake
// Revision : 1.0 - initial release
// ============================================================================
module mbr_store_buffer #(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_req,
  input  logic          st_req,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] acc_in,
  output logic [DW-1:0] mbr_out,
  output logic          mbr_valid,
  output logic          busy,
  output logic          st_full,
  output logic          st_overflow,
  output logic          mem_rd_req,
  output logic [AW-1:0] mem_rd_addr,
  input  logic          mem_rd_ack,
  input  logic [DW-1:0] mem_rd_data,
  output logic          mem_wr_valid,
  output logic [AW-1:0] mem_wr_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic          mem_wr_ready
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);
  localparam logic [PW:0] C_ONE   = (PW+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_RD    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] fifo_addr_q [DEPTH];
  logic [AW-1:0] fifo_addr_d [DEPTH];
  logic [DW-1:0] fifo_data_q [DEPTH];
  logic [DW-1:0] fifo_data_d [DEPTH];
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic [DW-1:0] mbr_out_q, mbr_out_d;
  logic          mbr_valid_q, mbr_valid_d;
  logic          st_overflow_q, st_overflow_d;

  logic          w_push;
  logic          w_pop;
  logic          w_fifo_empty;
  logic          w_fwd_hit;
  logic [DW-1:0] w_fwd_data;

  // --------------------------------------------------------------------------
  // Store FIFO
  // --------------------------------------------------------------------------
  assign w_fifo_empty = (count_q == '0);
  assign st_full      = (count_q == C_DEPTH);
  assign w_push       = st_req && !st_full;
  assign w_pop        = !w_fifo_empty && mem_wr_ready;

  always_comb begin
    fifo_addr_d   = fifo_addr_q;
    fifo_data_d   = fifo_data_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    st_overflow_d = st_overflow_q | (st_req & st_full);
    if (w_push) begin
      fifo_addr_d[wr_ptr_q] = addr_in;
      fifo_data_d[wr_ptr_q] = acc_in;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leave the occupancy unchanged.
    if (w_push && !w_pop) begin
      count_d = count_q + C_ONE;
    end else if (!w_push && w_pop) begin
      count_d = count_q - C_ONE;
    end
  end

  // Head is read straight from registered storage so the write handshake
  // completes in the cycle ready is seen. Gated to 0 while empty.
  assign mem_wr_valid = !w_fifo_empty;
  assign mem_wr_addr  = w_fifo_empty ? '0 : fifo_addr_q[rd_ptr_q];
  assign mem_wr_data  = w_fifo_empty ? '0 : fifo_data_q[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Store-to-load forwarding
  // --------------------------------------------------------------------------
`ifdef MBR_FWD_EN
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    // Scan oldest to youngest so the last match is the youngest.
    for (int k = 0; k < DEPTH; k++) begin
      if (((PW+1)'(k) < count_q) &&
          (fifo_addr_q[rd_ptr_q + PW'(k)] == addr_in)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = fifo_data_q[rd_ptr_q + PW'(k)];
      end
    end
    // A store accepted this cycle shares addr_in, so it is always the
    // youngest match.
    if (w_push) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = acc_in;
    end
  end
`else
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = '0;
`endif

  // --------------------------------------------------------------------------
  // Load FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ld_req && !w_fwd_hit) begin
          // Older stores (including this cycle's) must reach memory first.
          state_d = (count_d == '0) ? S_RD : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count_d == '0) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (mem_rd_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy       = (state_q != S_IDLE);
    mem_rd_req = (state_q == S_RD);
  end

  assign mem_rd_addr = ld_addr_q;

  // --------------------------------------------------------------------------
  // Load datapath
  // --------------------------------------------------------------------------
  always_comb begin
    ld_addr_d   = ld_addr_q;
    mbr_out_d   = mbr_out_q;
    mbr_valid_d = 1'b0;
    if ((state_q == S_IDLE) && ld_req) begin
      ld_addr_d = addr_in;
      if (w_fwd_hit) begin
        mbr_out_d   = w_fwd_data;
        mbr_valid_d = 1'b1;
      end
    end
    if ((state_q == S_RD) && mem_rd_ack) begin
      mbr_out_d   = mem_rd_data;
      mbr_valid_d = 1'b1;
    end
  end

  assign mbr_out     = mbr_out_q;
  assign mbr_valid   = mbr_valid_q;
  assign st_overflow = st_overflow_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ld_addr_q     <= '0;
      mbr_out_q     <= '0;
      mbr_valid_q   <= 1'b0;
      st_overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ld_addr_q     <= ld_addr_d;
      mbr_out_q     <= mbr_out_d;
      mbr_valid_q   <= mbr_valid_d;
      st_overflow_q <= st_overflow_d;
      fifo_addr_q   <= fifo_addr_d;
      fifo_data_q   <= fifo_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mbr_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbr_store_buffer
// Purpose  : Directed, table-driven bench for mbr_store_buffer. Each record
//            holds one cycle of inputs and the outputs expected after the
//            following rising edge.
// Options  : MBR_FWD_EN - selects forwarding expectations for the
//            load-after-store sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbr_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req = 1'b0;
  logic        st_req = 1'b0;
  logic [7:0]  addr_in = '0;
  logic [15:0] acc_in = '0;
  logic [15:0] mbr_out;
  logic        mbr_valid;
  logic        busy;
  logic        st_full;
  logic        st_overflow;
  logic        mem_rd_req;
  logic [7:0]  mem_rd_addr;
  logic        mem_rd_ack = 1'b0;
  logic [15:0] mem_rd_data = '0;
  logic        mem_wr_valid;
  logic [7:0]  mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        mem_wr_ready = 1'b0;

  always #5 clk = ~clk;

  mbr_store_buffer #(.DW(16), .AW(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_req       (ld_req),
    .st_req       (st_req),
    .addr_in      (addr_in),
    .acc_in       (acc_in),
    .mbr_out      (mbr_out),
    .mbr_valid    (mbr_valid),
    .busy         (busy),
    .st_full      (st_full),
    .st_overflow  (st_overflow),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ack   (mem_rd_ack),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [7:0]  addr;
    logic [15:0] acc;
    logic        ack;
    logic [15:0] rdata;
    logic        wrdy;
    logic [15:0] e_out;
    logic        e_vld;
    logic        e_busy;
    logic        e_full;
    logic        e_ovf;
    logic        e_rreq;
    logic [7:0]  e_raddr;
    logic        e_wv;
    logic [7:0]  e_waddr;
    logic [15:0] e_wdata;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(
    input logic ld, input logic st, input logic [7:0] addr, input logic [15:0] acc,
    input logic ack, input logic [15:0] rdata, input logic wrdy,
    input logic [15:0] e_out, input logic e_vld, input logic e_busy,
    input logic e_full, input logic e_ovf, input logic e_rreq,
    input logic [7:0] e_raddr, input logic e_wv, input logic [7:0] e_waddr,
    input logic [15:0] e_wdata);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = addr; v.acc = acc;
    v.ack = ack; v.rdata = rdata; v.wrdy = wrdy;
    v.e_out = e_out; v.e_vld = e_vld; v.e_busy = e_busy; v.e_full = e_full;
    v.e_ovf = e_ovf; v.e_rreq = e_rreq; v.e_raddr = e_raddr;
    v.e_wv = e_wv; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    return v;
  endfunction

  task automatic check(input string nm, input vec_t v);
    logic [53:0] act;
    logic [53:0] exp;
    act = {mbr_out, mbr_valid, busy, st_full, st_overflow, mem_rd_req,
           mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data};
    exp = {v.e_out, v.e_vld, v.e_busy, v.e_full, v.e_ovf, v.e_rreq,
           v.e_raddr, v.e_wv, v.e_waddr, v.e_wdata};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {out,vld,busy,full,ovf,rreq,raddr,wv,waddr,wdata} got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic apply(input string nm, input vec_t v);
    @(negedge clk);
    ld_req       = v.ld;
    st_req       = v.st;
    addr_in      = v.addr;
    acc_in       = v.acc;
    mem_rd_ack   = v.ack;
    mem_rd_data  = v.rdata;
    mem_wr_ready = v.wrdy;
    @(posedge clk);
    #1;
    check(nm, v);
  endtask

  vec_t tbl [16];
  vec_t seq3 [8];
  vec_t zero_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Load with 3-cycle memory latency, then posted stores, overflow and
    // in-order drain, then two entries queued for the push/pop test.
    tbl[0]  = mk(1,0,8'h10,16'h0000, 0,16'h0000,0, 16'h0000,0,1,0,0,1,8'h10, 0,8'h00,16'h0000);
    tbl[1]  = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'h0000,0,1,0,0,1,8'h10, 0,8'h00,16'h0000);
    tbl[2]  = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'h0000,0,1,0,0,1,8'h10, 0,8'h00,16'h0000);
    tbl[3]  = mk(0,0,8'h00,16'h0000, 1,16'hBEEF,0, 16'hBEEF,1,0,0,0,0,8'h10, 0,8'h00,16'h0000);
    tbl[4]  = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'hBEEF,0,0,0,0,0,8'h10, 0,8'h00,16'h0000);
    tbl[5]  = mk(0,1,8'h01,16'hA001, 0,16'h0000,0, 16'hBEEF,0,0,0,0,0,8'h10, 1,8'h01,16'hA001);
    tbl[6]  = mk(0,1,8'h02,16'hA002, 0,16'h0000,0, 16'hBEEF,0,0,0,0,0,8'h10, 1,8'h01,16'hA001);
    tbl[7]  = mk(0,1,8'h03,16'hA003, 0,16'h0000,0, 16'hBEEF,0,0,0,0,0,8'h10, 1,8'h01,16'hA001);
    tbl[8]  = mk(0,1,8'h04,16'hA004, 0,16'h0000,0, 16'hBEEF,0,0,1,0,0,8'h10, 1,8'h01,16'hA001);
    tbl[9]  = mk(0,1,8'h05,16'hA005, 0,16'h0000,0, 16'hBEEF,0,0,1,1,0,8'h10, 1,8'h01,16'hA001);
    tbl[10] = mk(0,0,8'h00,16'h0000, 0,16'h0000,1, 16'hBEEF,0,0,0,1,0,8'h10, 1,8'h02,16'hA002);
    tbl[11] = mk(0,0,8'h00,16'h0000, 0,16'h0000,1, 16'hBEEF,0,0,0,1,0,8'h10, 1,8'h03,16'hA003);
    tbl[12] = mk(0,0,8'h00,16'h0000, 0,16'h0000,1, 16'hBEEF,0,0,0,1,0,8'h10, 1,8'h04,16'hA004);
    tbl[13] = mk(0,0,8'h00,16'h0000, 0,16'h0000,1, 16'hBEEF,0,0,0,1,0,8'h10, 0,8'h00,16'h0000);
    tbl[14] = mk(0,1,8'h11,16'hB011, 0,16'h0000,0, 16'hBEEF,0,0,0,1,0,8'h10, 1,8'h11,16'hB011);
    tbl[15] = mk(0,1,8'h12,16'hB012, 0,16'h0000,0, 16'hBEEF,0,0,0,1,0,8'h10, 1,8'h11,16'hB011);

    // Load after store with the write held off for 5 cycles.
`ifdef MBR_FWD_EN
    seq3[0] = mk(0,1,8'h20,16'h1234, 0,16'h0000,0, 16'h0000,0,0,0,0,0,8'h00, 1,8'h20,16'h1234);
    seq3[1] = mk(1,0,8'h20,16'h0000, 0,16'h0000,0, 16'h1234,1,0,0,0,0,8'h20, 1,8'h20,16'h1234);
    seq3[2] = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'h1234,0,0,0,0,0,8'h20, 1,8'h20,16'h1234);
    seq3[3] = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'h1234,0,0,0,0,0,8'h20, 1,8'h20,16'h1234);
    seq3[4] = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'h1234,0,0,0,0,0,8'h20, 1,8'h20,16'h1234);
    seq3[5] = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'h1234,0,0,0,0,0,8'h20, 1,8'h20,16'h1234);
    seq3[6] = mk(0,0,8'h00,16'h0000, 0,16'h0000,1, 16'h1234,0,0,0,0,0,8'h20, 0,8'h00,16'h0000);
    seq3[7] = mk(0,0,8'h00,16'h0000, 1,16'h9999,0, 16'h1234,0,0,0,0,0,8'h20, 0,8'h00,16'h0000);
`else
    seq3[0] = mk(0,1,8'h20,16'h1234, 0,16'h0000,0, 16'h0000,0,0,0,0,0,8'h00, 1,8'h20,16'h1234);
    seq3[1] = mk(1,0,8'h20,16'h0000, 0,16'h0000,0, 16'h0000,0,1,0,0,0,8'h20, 1,8'h20,16'h1234);
    seq3[2] = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'h0000,0,1,0,0,0,8'h20, 1,8'h20,16'h1234);
    seq3[3] = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'h0000,0,1,0,0,0,8'h20, 1,8'h20,16'h1234);
    seq3[4] = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'h0000,0,1,0,0,0,8'h20, 1,8'h20,16'h1234);
    seq3[5] = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'h0000,0,1,0,0,0,8'h20, 1,8'h20,16'h1234);
    seq3[6] = mk(0,0,8'h00,16'h0000, 0,16'h0000,1, 16'h0000,0,1,0,0,1,8'h20, 0,8'h00,16'h0000);
    seq3[7] = mk(0,0,8'h00,16'h0000, 1,16'h9999,0, 16'h9999,1,0,0,0,0,8'h20, 0,8'h00,16'h0000);
`endif

    zero_v = mk(0,0,8'h00,16'h0000, 0,16'h0000,0, 16'h0000,0,0,0,0,0,8'h00, 0,8'h00,16'h0000);

    // Reset state, with a stray ack present during reset.
    mem_rd_ack  = 1'b1;
    mem_rd_data = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", zero_v);
    @(negedge clk);
    rst_n = 1'b1;

    // A leftover ack right after reset must not update mbr_out.
    apply("post_reset_ack", mk(0,0,8'h00,16'h0000, 1,16'hDEAD,0,
                               16'h0000,0,0,0,0,0,8'h00, 0,8'h00,16'h0000));

    for (int i = 0; i < 16; i++) begin
      apply($sformatf("tbl[%0d]", i), tbl[i]);
    end

    // Push and pop every cycle at count 2; 12 pushes wrap the pointers 3x.
    for (int k = 0; k < 12; k++) begin
      apply($sformatf("pushpop[%0d]", k),
            mk(0,1,8'h13 + 8'(k),16'hB013 + 16'(k), 0,16'h0000,1,
               16'hBEEF,0,0,0,1,0,8'h10, 1,8'h12 + 8'(k),16'hB012 + 16'(k)));
    end
    apply("drain_last0", mk(0,0,8'h00,16'h0000, 0,16'h0000,1,
                            16'hBEEF,0,0,0,1,0,8'h10, 1,8'h1E,16'hB01E));
    apply("drain_last1", mk(0,0,8'h00,16'h0000, 0,16'h0000,1,
                            16'hBEEF,0,0,0,1,0,8'h10, 0,8'h00,16'h0000));

    // Reset while in RD with an ack pending and a store queued.
    apply("rd_before_reset", mk(1,0,8'h33,16'h0000, 0,16'h0000,0,
                                16'hBEEF,0,1,0,1,1,8'h33, 0,8'h00,16'h0000));
    apply("st_while_busy", mk(0,1,8'h40,16'hC040, 0,16'h0000,0,
                              16'hBEEF,0,1,0,1,1,8'h33, 1,8'h40,16'hC040));
    @(negedge clk);
    ld_req      = 1'b0;
    st_req      = 1'b0;
    mem_rd_ack  = 1'b1;
    mem_rd_data = 16'h5555;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", zero_v);
    @(posedge clk);
    #1;
    check("reset_hold_ack", zero_v);
    @(negedge clk);
    rst_n = 1'b1;
    apply("ack_after_reset", mk(0,0,8'h00,16'h0000, 1,16'h5555,0,
                                16'h0000,0,0,0,0,0,8'h00, 0,8'h00,16'h0000));

    for (int i = 0; i < 8; i++) begin
      apply($sformatf("ld_after_st[%0d]", i), seq3[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
